// File: rtl/key_autorepeat.sv
// key_autorepeat: per-channel key debouncer with press/release pulses and
// keyboard-style auto-repeat (an initial delay, then a fixed repeat rate).
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst          asynchronous active-high reset
//   raw_i        asynchronous key levels, 1 = pressed
//   rep_en_i     per-channel auto-repeat enable, sampled every cycle
//   hold_i       global pause: timing counters freeze and press/fire are
//                suppressed (debounce, level and release keep running)
//   level_o      debounced key level
//   press_o      one-cycle pulse on an accepted press
//   release_o    one-cycle pulse on an accepted release
//   fire_o       one-cycle action pulse on press and on each auto-repeat
//   fire_any_o   OR of fire_o
//   fire_idx_o   lowest set bit index of fire_o, 0 when none is set
module key_autorepeat #(
  parameter int unsigned N          = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DAS_CYCLES = 20,
  parameter int unsigned ARR_CYCLES = 5,
  parameter int unsigned CW         = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_i,
  input  logic [N-1:0] rep_en_i,
  input  logic         hold_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] fire_o,
  output logic         fire_any_o,
  output logic [4:0]   fire_idx_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_e;

  // Terminal counts: the action happens on the edge where the counter
  // would otherwise step past (LIMIT - 1).
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DAS_LAST = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);

  logic [N-1:0]  sync1_q;
  logic [N-1:0]  sync2_q;
  logic [CW-1:0] deb_q [N];
  logic [CW-1:0] deb_d [N];
  logic [CW-1:0] tmr_q [N];
  logic [CW-1:0] tmr_d [N];
  state_e        st_q  [N];
  state_e        st_d  [N];
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q,   rel_d;
  logic [N-1:0]  fire_q,  fire_d;
  logic          fire_any_q, fire_any_d;
  logic [4:0]    fire_idx_q, fire_idx_d;

  // Next-state logic for debounce, per-channel FSM and pulse outputs.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    fire_d  = '0;
    for (int i = 0; i < N; i++) begin
      deb_d[i] = deb_q[i];
      tmr_d[i] = tmr_q[i];
      st_d[i]  = st_q[i];

      // Debounce: count consecutive disagreeing cycles, flip on the last one.
      if (sync2_q[i] == level_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_LAST) begin
        deb_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        deb_d[i] = deb_q[i] + CW'(1);
      end

      if (level_d[i] && !level_q[i]) begin
        // Accepted press: the state is entered even under hold, only the
        // pulses are withheld; timing starts counting once hold drops.
        press_d[i] = ~hold_i;
        fire_d[i]  = ~hold_i;
        tmr_d[i]   = '0;
        st_d[i]    = rep_en_i[i] ? DELAY : HELD;
      end else if (!level_d[i] && level_q[i]) begin
        rel_d[i] = 1'b1;
        tmr_d[i] = '0;
        st_d[i]  = IDLE;
      end else begin
        case (st_q[i])
          DELAY: begin
            if (!rep_en_i[i]) begin
              st_d[i]  = HELD;
              tmr_d[i] = '0;
            end else if (!hold_i) begin
              if (tmr_q[i] == DAS_LAST) begin
                fire_d[i] = 1'b1;
                tmr_d[i]  = '0;
                st_d[i]   = REPEAT;
              end else begin
                tmr_d[i] = tmr_q[i] + CW'(1);
              end
            end
          end
          REPEAT: begin
            if (!rep_en_i[i]) begin
              st_d[i]  = HELD;
              tmr_d[i] = '0;
            end else if (!hold_i) begin
              if (tmr_q[i] == ARR_LAST) begin
                fire_d[i] = 1'b1;
                tmr_d[i]  = '0;
              end else begin
                tmr_d[i] = tmr_q[i] + CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Priority encode: scanning downward leaves the lowest set index.
    fire_any_d = |fire_d;
    fire_idx_d = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (fire_d[i]) fire_idx_d = 5'(i);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      fire_q     <= '0;
      fire_any_q <= 1'b0;
      fire_idx_q <= '0;
      for (int i = 0; i < N; i++) begin
        deb_q[i] <= '0;
        tmr_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      fire_q     <= fire_d;
      fire_any_q <= fire_any_d;
      fire_idx_q <= fire_idx_d;
      for (int i = 0; i < N; i++) begin
        deb_q[i] <= deb_d[i];
        tmr_q[i] <= tmr_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  assign level_o    = level_q;
  assign press_o    = press_q;
  assign release_o  = rel_q;
  assign fire_o     = fire_q;
  assign fire_any_o = fire_any_q;
  assign fire_idx_o = fire_idx_q;

endmodule
